// File: rtl/multi_timer.sv
// Multi-channel programmable timer with one-shot, auto-reload and free-run modes.
// Per-channel CTRL/PRESET/COUNT/STATUS registers behind a byte-enabled word bus.
module multi_timer #(
    parameter int NCH     = 4,
    parameter int CH_BITS = 2,
    parameter int CW      = 32
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic [CH_BITS+3:2] ADD_I,
    input  logic               WE_I,
    input  logic [31:0]        DAT_I,
    input  logic [3:0]         BE,
    output logic [31:0]        DAT_O,
    output logic               IRQ
);

    logic [CH_BITS-1:0] w_ch;
    logic [1:0]         w_reg;

    logic [NCH-1:0]         w_en_a;
    logic [NCH-1:0]         w_im_a;
    logic [NCH-1:0]         w_done_a;
    logic [NCH-1:0][1:0]    w_mode_a;
    logic [NCH-1:0][CW-1:0] w_pre_a;
    logic [NCH-1:0][CW-1:0] w_cnt_a;

    assign w_ch  = ADD_I[CH_BITS+3:4];
    assign w_reg = ADD_I[3:2];

    function automatic logic [CW-1:0] f_merge(
        input logic [CW-1:0] old,
        input logic [31:0]   dat,
        input logic [3:0]    be
    );
        logic [31:0] v;
        v         = '0;
        v[CW-1:0] = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) v[8*b +: 8] = dat[8*b +: 8];
        end
        return v[CW-1:0];
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic          r_en;
        logic          r_im;
        logic          r_done;
        logic [1:0]    r_mode;
        logic [CW-1:0] r_preset;
        logic [CW-1:0] r_count;

        logic w_sel;
        logic w_wr_ctrl;
        logic w_wr_pre;
        logic w_wr_cnt;
        logic w_clr;
        logic w_up;
        logic w_zero;
        logic w_ones;
        logic w_fire;
        logic w_load;
        logic w_stop;

        assign w_sel     = WE_I && (w_ch == CH_BITS'(g));
        assign w_wr_ctrl = w_sel && (w_reg == 2'd0) && BE[0];
        assign w_wr_pre  = w_sel && (w_reg == 2'd1);
        assign w_wr_cnt  = w_sel && (w_reg == 2'd2);
        assign w_clr     = w_sel && (w_reg == 2'd3) && BE[0] && DAT_I[0];

        assign w_up   = (r_mode == 2'b10);
        assign w_zero = (r_count == '0);
        assign w_ones = &r_count;
        assign w_fire = r_en && (w_up ? w_ones : w_zero);
        assign w_load = w_wr_ctrl && !r_en && DAT_I[0];
        // Only the one-shot flavours (00, 11) stop themselves on expiry
        assign w_stop = w_fire && !w_up && (r_mode != 2'b01);

        always_ff @(posedge CLK_I or negedge RST_I) begin
            if (!RST_I) begin
                r_en     <= 1'b0;
                r_im     <= 1'b0;
                r_mode   <= 2'b00;
                r_done   <= 1'b0;
                r_preset <= '0;
                r_count  <= '0;
            end else begin
                if (w_wr_ctrl) begin
                    r_en   <= DAT_I[0];
                    r_mode <= DAT_I[2:1];
                    r_im   <= DAT_I[3];
                end else if (w_stop) begin
                    r_en <= 1'b0;
                end

                if (w_wr_pre) r_preset <= f_merge(r_preset, DAT_I, BE);

                if (w_wr_cnt) begin
                    r_count <= f_merge(r_count, DAT_I, BE);
                end else if (w_load) begin
                    r_count <= r_preset;
                end else if (r_en) begin
                    if (w_up)                    r_count <= r_count + 1'b1;
                    else if (!w_zero)            r_count <= r_count - 1'b1;
                    else if (r_mode == 2'b01)    r_count <= r_preset;
                end

                if (w_fire)     r_done <= 1'b1;
                else if (w_clr) r_done <= 1'b0;
            end
        end

        assign w_en_a[g]   = r_en;
        assign w_im_a[g]   = r_im;
        assign w_done_a[g] = r_done;
        assign w_mode_a[g] = r_mode;
        assign w_pre_a[g]  = r_preset;
        assign w_cnt_a[g]  = r_count;
    end

    always_comb begin
        DAT_O = '0;
        unique case (w_reg)
            2'd0: DAT_O[3:0]    = {w_im_a[w_ch], w_mode_a[w_ch], w_en_a[w_ch]};
            2'd1: DAT_O[CW-1:0] = w_pre_a[w_ch];
            2'd2: DAT_O[CW-1:0] = w_cnt_a[w_ch];
            2'd3: DAT_O[0]      = w_done_a[w_ch];
        endcase
    end

    assign IRQ = |(w_done_a & w_im_a);

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus randomized bus traffic
// compared against a per-channel behavioural model.
module tb_multi_timer;

    logic        CLK_I;
    logic        RST_I;
    logic [5:2]  ADD_I;
    logic        WE_I;
    logic [31:0] DAT_I;
    logic [3:0]  BE;
    logic [31:0] DAT_O;
    logic        IRQ;

    int n_tests;
    int n_fail;

    logic        m_en   [4];
    logic        m_im   [4];
    logic        m_done [4];
    logic [1:0]  m_mode [4];
    logic [31:0] m_pre  [4];
    logic [31:0] m_cnt  [4];

    multi_timer #(.NCH(4), .CH_BITS(2), .CW(32)) dut (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .ADD_I(ADD_I),
        .WE_I (WE_I),
        .DAT_I(DAT_I),
        .BE   (BE),
        .DAT_O(DAT_O),
        .IRQ  (IRQ)
    );

    initial CLK_I = 1'b0;
    always #50 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] old,
                                           input logic [31:0] dat,
                                           input logic [3:0]  be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (dat & mask);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_en[c] = 0; m_im[c] = 0; m_done[c] = 0;
            m_mode[c] = 0; m_pre[c] = 0; m_cnt[c] = 0;
        end
    endtask

    task automatic model_step(input logic we, input int ch, input int rg,
                              input logic [31:0] dat, input logic [3:0] be);
        for (int c = 0; c < 4; c++) begin
            logic        fire, n_en, n_im, n_done;
            logic [1:0]  n_mode;
            logic [31:0] n_pre, n_cnt;
            fire = m_en[c] && ((m_mode[c] == 2) ? (m_cnt[c] == 32'hFFFF_FFFF)
                                                : (m_cnt[c] == 0));
            n_en = m_en[c]; n_im = m_im[c]; n_mode = m_mode[c];
            n_pre = m_pre[c]; n_cnt = m_cnt[c]; n_done = m_done[c];
            if (m_en[c]) begin
                case (m_mode[c])
                    2: n_cnt = m_cnt[c] + 1;
                    1: n_cnt = (m_cnt[c] == 0) ? m_pre[c] : m_cnt[c] - 1;
                    default: begin
                        if (m_cnt[c] != 0) n_cnt = m_cnt[c] - 1;
                        else n_en = 0;
                    end
                endcase
            end
            if (fire) n_done = 1;
            if (we && ch == c) begin
                case (rg)
                    0: if (be[0]) begin
                        n_en = dat[0]; n_mode = dat[2:1]; n_im = dat[3];
                        if (!m_en[c] && dat[0]) n_cnt = m_pre[c];
                    end
                    1: n_pre = bmerge(m_pre[c], dat, be);
                    2: n_cnt = bmerge(m_cnt[c], dat, be);
                    default: if (be[0] && dat[0] && !fire) n_done = 0;
                endcase
            end
            m_en[c] = n_en; m_im[c] = n_im; m_mode[c] = n_mode;
            m_pre[c] = n_pre; m_cnt[c] = n_cnt; m_done[c] = n_done;
        end
    endtask

    function automatic logic [31:0] m_read(input int c, input int rg);
        case (rg)
            0:       return {28'd0, m_im[c], m_mode[c], m_en[c]};
            1:       return m_pre[c];
            2:       return m_cnt[c];
            default: return {31'd0, m_done[c]};
        endcase
    endfunction

    task automatic cyc(input logic we, input int ch, input int rg,
                       input logic [31:0] dat, input logic [3:0] be);
        WE_I  = we;
        ADD_I = {2'(ch), 2'(rg)};
        DAT_I = dat;
        BE    = be;
        @(posedge CLK_I);
        if (RST_I) model_step(we, ch, rg, dat, be);
        #1;
        WE_I = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 32'd0, 4'd0);
    endtask

    task automatic rd_chk(input string tag, input int ch, input int rg,
                          input logic [31:0] exp);
        ADD_I = {2'(ch), 2'(rg)};
        #1;
        chk(tag, DAT_O, exp);
    endtask

    task automatic check_all(input string tag);
        logic irq_exp;
        irq_exp = 0;
        for (int c = 0; c < 4; c++) begin
            irq_exp |= m_done[c] & m_im[c];
            for (int r = 0; r < 4; r++)
                rd_chk($sformatf("%s ch%0d r%0d", tag, c, r), c, r, m_read(c, r));
        end
        chk({tag, " irq"}, {31'd0, IRQ}, {31'd0, irq_exp});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST_I = 1'b0;
        WE_I  = 1'b0;
        ADD_I = '0;
        DAT_I = '0;
        BE    = '0;
        model_reset();
        #2;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rd_chk($sformatf("rst ch%0d r%0d", c, r), c, r, 32'd0);
        chk("rst irq", {31'd0, IRQ}, 32'd0);
        idle(2);
        RST_I = 1'b1;

        // one-shot countdown on ch0
        cyc(1, 0, 1, 32'd5, 4'hF);
        rd_chk("first wr preset", 0, 1, 32'd5);
        rd_chk("preset no load", 0, 2, 32'd0);
        cyc(1, 0, 0, 32'h9, 4'hF);
        rd_chk("os load", 0, 2, 32'd5);
        for (int i = 4; i >= 0; i--) begin
            idle(1);
            rd_chk($sformatf("os cnt%0d", i), 0, 2, 32'(i));
            rd_chk("os notdone", 0, 3, 32'd0);
        end
        idle(1);
        rd_chk("os done", 0, 3, 32'd1);
        rd_chk("os en off", 0, 0, 32'h8);
        rd_chk("os hold0", 0, 2, 32'd0);
        chk("os irq", {31'd0, IRQ}, 32'd1);
        check_all("os");

        // auto-reload on ch1
        cyc(1, 0, 3, 32'd1, 4'h1);
        chk("w1c irq", {31'd0, IRQ}, 32'd0);
        cyc(1, 1, 1, 32'd3, 4'hF);
        cyc(1, 1, 0, 32'hB, 4'hF);
        idle(3);
        rd_chk("ar early", 1, 3, 32'd0);
        idle(1);
        rd_chk("ar done", 1, 3, 32'd1);
        rd_chk("ar reload", 1, 2, 32'd3);
        chk("ar irq", {31'd0, IRQ}, 32'd1);
        cyc(1, 1, 3, 32'd1, 4'h1);
        rd_chk("ar clr", 1, 3, 32'd0);
        chk("ar irq clr", {31'd0, IRQ}, 32'd0);
        idle(2);
        rd_chk("ar early2", 1, 3, 32'd0);
        idle(1);
        rd_chk("ar done2", 1, 3, 32'd1);
        cyc(1, 1, 0, 32'd0, 4'hF);
        cyc(1, 1, 3, 32'd1, 4'h1);
        check_all("ar");

        // free-run wrap on ch2, IM=0
        cyc(1, 2, 1, 32'hFFFF_FFFE, 4'hF);
        cyc(1, 2, 0, 32'h5, 4'hF);
        rd_chk("fr load", 2, 2, 32'hFFFF_FFFE);
        idle(1);
        rd_chk("fr ones", 2, 2, 32'hFFFF_FFFF);
        rd_chk("fr notdone", 2, 3, 32'd0);
        idle(1);
        rd_chk("fr wrap", 2, 2, 32'd0);
        rd_chk("fr done", 2, 3, 32'd1);
        rd_chk("fr en kept", 2, 0, 32'h5);
        chk("fr irq low", {31'd0, IRQ}, 32'd0);
        cyc(1, 2, 0, 32'd0, 4'hF);
        cyc(1, 2, 3, 32'd1, 4'h1);

        // bus override of count and done
        cyc(1, 0, 1, 32'h20, 4'hF);
        cyc(1, 0, 0, 32'h1, 4'hF);
        idle(1);
        rd_chk("ov dec", 0, 2, 32'h1F);
        cyc(1, 0, 2, 32'h10, 4'hF);
        rd_chk("ov cnt", 0, 2, 32'h10);
        cyc(1, 0, 2, 32'h0, 4'hF);
        rd_chk("ov zero", 0, 3, 32'd0);
        cyc(1, 0, 3, 32'd1, 4'h1);
        rd_chk("ov setwins", 0, 3, 32'd1);
        cyc(1, 0, 3, 32'd1, 4'h1);
        rd_chk("ov clr", 0, 3, 32'd0);

        // partial byte enables
        cyc(1, 3, 1, 32'hAABB_CCDD, 4'b0101);
        rd_chk("be preset", 3, 1, 32'h00BB_00DD);
        check_all("dir");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int          ch, rg;
            logic        we;
            logic [31:0] dat;
            logic [3:0]  be;
            we  = ($urandom_range(0, 3) != 0);
            ch  = $urandom_range(0, 3);
            rg  = $urandom_range(0, 3);
            be  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case ($urandom_range(0, 7))
                0:       dat = $urandom;
                1:       dat = 32'hFFFF_FFFF - $urandom_range(0, 6);
                default: dat = $urandom_range(0, 15);
            endcase
            cyc(we, ch, rg, dat, be);
            check_all("rnd");
        end

        // asynchronous reset mid-count
        for (int c = 0; c < 4; c++) begin
            cyc(1, c, 1, 32'(c * 3), 4'hF);
            cyc(1, c, 0, 32'h9, 4'hF);
        end
        idle(3);
        check_all("pre-rst");
        #10;
        RST_I = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rd_chk($sformatf("arst ch%0d r%0d", c, r), c, r, 32'd0);
        chk("arst irq", {31'd0, IRQ}, 32'd0);
        idle(2);
        RST_I = 1'b1;
        idle(4);
        rd_chk("post rst cnt", 0, 2, 32'd0);
        rd_chk("post rst done", 0, 3, 32'd0);
        check_all("post-rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
